nn_input_packer: RTL and testbench

- Front-end producer for the neural-network datapath. Accepts a serial pixel stream over a valid/ready handshake.
- Assembles numInputs pixels into the flat NNin vector, then pulses NNvalid to launch one inference.
- Optionally holds NNin stable and refuses new pixels until the network's result strobe (maxValid) returns. This prevents overwriting the frame mid-computation.

---
 rtl/nn_input_packer.sv | 84 ++++++++
 tb/tb_nn_input_packer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_input_packer.sv
// nn_input_packer: packs a serial valid/ready pixel stream into the flat NNin frame
// and pulses NNvalid once per completed frame, optionally holding until the result.
//
// state | meaning
// FILL  | accepting pixels into NNin, pixReady high
// FIRE  | one-cycle NNvalid launch, frame complete and stable
// WAIT  | frame frozen until resultValid returns
module nn_input_packer #(
  parameter int dataWidth     = 8,
  parameter int numInputs     = 784,
  parameter bit waitForResult = 1'b1,
  parameter int cntWidth      = $clog2(numInputs)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [dataWidth-1:0]           pixIn,
  input  logic                           pixValid,
  input  logic                           pixSof,
  output logic                           pixReady,
  input  logic                           resultValid,
  output logic [dataWidth*numInputs-1:0] NNin,
  output logic                           NNvalid,
  output logic [cntWidth-1:0]            pixCount,
  output logic [15:0]                    framesSent
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [cntWidth-1:0] LAST_IDX = cntWidth'(numInputs - 1);

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic                 last_beat;
  logic [cntWidth-1:0]  target;

  assign pixReady  = (state == FILL);
  assign accept    = pixValid && pixReady;
  // A start-of-frame beat always lands in slot 0, aborting any partial frame.
  assign target    = pixSof ? '0 : pixCount;
  assign last_beat = (target == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (accept && last_beat) state_next = FIRE;
      FIRE:    state_next = waitForResult ? WAIT : FILL;
      WAIT:    if (resultValid) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      NNin       <= '0;
      NNvalid    <= 1'b0;
      pixCount   <= '0;
      framesSent <= '0;
    end else begin
      // Registered so NNvalid is high exactly while state is FIRE.
      NNvalid <= (state_next == FIRE);
      if (accept) begin
        NNin[target*dataWidth +: dataWidth] <= pixIn;
        pixCount <= last_beat ? '0 : target + 1'b1;
      end
      if (state == FIRE) begin
        framesSent <= framesSent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_nn_input_packer.sv
// Bench for nn_input_packer: three instances (4x8 waiting, 4x8 free-running, 784x8 waiting)
// checked against directed expectations and a queue/array-level behavioural model.
module tb_nn_input_packer;
  localparam int NBIG = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] pd [3];
  logic       pv [3];
  logic       ps [3];
  logic       rv [3];

  logic            rdy_a, rdy_b, rdy_c;
  logic            val_a, val_b, val_c;
  logic [31:0]     nn_a, nn_b;
  logic [8*NBIG-1:0] nn_c;
  logic [1:0]      cnt_a, cnt_b;
  logic [9:0]      cnt_c;
  logic [15:0]     fr_a, fr_b, fr_c;

  nn_input_packer #(.dataWidth(8), .numInputs(4), .waitForResult(1'b1)) dut_a (
    .clk(clk), .reset(reset), .pixIn(pd[0]), .pixValid(pv[0]), .pixSof(ps[0]),
    .pixReady(rdy_a), .resultValid(rv[0]), .NNin(nn_a), .NNvalid(val_a),
    .pixCount(cnt_a), .framesSent(fr_a));

  nn_input_packer #(.dataWidth(8), .numInputs(4), .waitForResult(1'b0)) dut_b (
    .clk(clk), .reset(reset), .pixIn(pd[1]), .pixValid(pv[1]), .pixSof(ps[1]),
    .pixReady(rdy_b), .resultValid(rv[1]), .NNin(nn_b), .NNvalid(val_b),
    .pixCount(cnt_b), .framesSent(fr_b));

  nn_input_packer #(.dataWidth(8), .numInputs(NBIG), .waitForResult(1'b1)) dut_c (
    .clk(clk), .reset(reset), .pixIn(pd[2]), .pixValid(pv[2]), .pixSof(ps[2]),
    .pixReady(rdy_c), .resultValid(rv[2]), .NNin(nn_c), .NNvalid(val_c),
    .pixCount(cnt_c), .framesSent(fr_c));

  int checks = 0;
  int errors = 0;

  // Behavioural model: image array, pixels gathered so far, busy/launch flags.
  int           n_of [3] = '{4, 4, NBIG};
  bit           w_of [3] = '{1'b1, 1'b0, 1'b1};
  byte unsigned m_img [3][NBIG];
  int           m_fill [3];
  bit           m_busy [3];
  bit           m_fire [3];
  int           m_frames [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_fill[i] = 0; m_busy[i] = 1'b0; m_fire[i] = 1'b0; m_frames[i] = 0;
      for (int k = 0; k < NBIG; k++) m_img[i][k] = 8'h00;
    end
  endtask

  task automatic model_edge(int id);
    int k;
    if (m_fire[id]) begin
      m_fire[id] = 1'b0;
      m_frames[id]++;
      m_busy[id] = w_of[id];
    end else if (m_busy[id]) begin
      if (rv[id]) m_busy[id] = 1'b0;
    end else if (pv[id]) begin
      k = ps[id] ? 0 : m_fill[id];
      m_img[id][k] = pd[id];
      m_fill[id] = k + 1;
      if (m_fill[id] == n_of[id]) begin
        m_fill[id] = 0; m_fire[id] = 1'b1; m_busy[id] = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] exp_small(int id);
    return {m_img[id][3], m_img[id][2], m_img[id][1], m_img[id][0]};
  endfunction

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; ps[i] = 1'b0; rv[i] = 1'b0; pd[i] = 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (rdy_a !== 1'b1 || val_a !== 1'b0 || cnt_a !== 2'd0 || fr_a !== 16'd0 || nn_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_a rdy=%b val=%b cnt=%0d fr=%0d nn=%h exp 1 0 0 0 0", rdy_a, val_a, cnt_a, fr_a, nn_a);
    end
    checks++;
    if (rdy_c !== 1'b1 || val_c !== 1'b0 || cnt_c !== 10'd0 || fr_c !== 16'd0 || nn_c !== '0) begin
      errors++;
      $display("FAIL reset_c rdy=%b val=%b cnt=%0d fr=%0d exp 1 0 0 0 and NNin zero", rdy_c, val_c, cnt_c, fr_c);
    end
  endtask

  task automatic test_frame();
    logic [7:0] px [4];
    px = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      pv[0] = 1'b1; ps[0] = (i == 0); pd[0] = px[i];
      tick();
      if (i < 3) begin
        checks++;
        if (val_a !== 1'b0 || rdy_a !== 1'b1 || cnt_a !== 2'(i + 1)) begin
          errors++;
          $display("FAIL frame_fill[%0d] val=%b rdy=%b cnt=%0d exp 0 1 %0d", i, val_a, rdy_a, cnt_a, i + 1);
        end
      end
    end
    pv[0] = 1'b0; ps[0] = 1'b0;
    checks++;
    if (val_a !== 1'b1 || rdy_a !== 1'b0 || cnt_a !== 2'd0) begin
      errors++;
      $display("FAIL frame_fire val=%b rdy=%b cnt=%0d exp 1 0 0", val_a, rdy_a, cnt_a);
    end
    checks++;
    if (nn_a !== 32'h44332211) begin
      errors++;
      $display("FAIL frame_nnin got %h exp 44332211", nn_a);
    end
    tick();
    checks++;
    if (val_a !== 1'b0 || rdy_a !== 1'b0 || fr_a !== 16'd1) begin
      errors++;
      $display("FAIL frame_after val=%b rdy=%b fr=%0d exp 0 0 1", val_a, rdy_a, fr_a);
    end
  endtask

  task automatic test_wait();
    pv[0] = 1'b1; pd[0] = 8'h99;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rdy_a !== 1'b0 || val_a !== 1'b0 || cnt_a !== 2'd0 || nn_a !== 32'h44332211) begin
        errors++;
        $display("FAIL wait_hold[%0d] rdy=%b val=%b cnt=%0d nn=%h exp 0 0 0 44332211", i, rdy_a, val_a, cnt_a, nn_a);
      end
    end
    rv[0] = 1'b1;
    tick();
    rv[0] = 1'b0;
    checks++;
    if (rdy_a !== 1'b1 || cnt_a !== 2'd0 || nn_a !== 32'h44332211) begin
      errors++;
      $display("FAIL wait_release rdy=%b cnt=%0d nn=%h exp 1 0 44332211", rdy_a, cnt_a, nn_a);
    end
    tick();
    pv[0] = 1'b0;
    checks++;
    if (cnt_a !== 2'd1 || nn_a !== 32'h44332299) begin
      errors++;
      $display("FAIL wait_accept cnt=%0d nn=%h exp 1 44332299", cnt_a, nn_a);
    end
  endtask

  task automatic test_abort();
    logic [7:0] px [6];
    bit         sf [6];
    int         pulses;
    px = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    sf = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      pv[0] = 1'b1; ps[0] = sf[i]; pd[0] = px[i];
      tick();
      if (val_a === 1'b1) pulses++;
    end
    pv[0] = 1'b0; ps[0] = 1'b0;
    checks++;
    if (pulses !== 1 || val_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_pulses got %0d last_val=%b exp 1 1", pulses, val_a);
    end
    checks++;
    if (nn_a !== 32'hB3B2B1B0) begin
      errors++;
      $display("FAIL abort_nnin got %h exp b3b2b1b0", nn_a);
    end
    tick();
    rv[0] = 1'b1;
    tick();
    rv[0] = 1'b0;
    checks++;
    if (rdy_a !== 1'b1 || fr_a !== 16'd2) begin
      errors++;
      $display("FAIL abort_release rdy=%b fr=%0d exp 1 2", rdy_a, fr_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] beats [16];
    int         pulse_at [$];
    int         j;
    bit         acc;
    logic [31:0] want;
    for (int i = 0; i < 16; i++) beats[i] = 8'($urandom);
    j = 0;
    for (int t = 1; t <= 15; t++) begin
      pv[1] = 1'b1; pd[1] = beats[j]; ps[1] = (j % 4 == 0);
      acc = !m_busy[1];
      tick();
      if (acc) j++;
      checks++;
      if (rdy_b !== !val_b) begin
        errors++;
        $display("FAIL b2b_ready t=%0d rdy=%b val=%b exp rdy=!val", t, rdy_b, val_b);
      end
      if (val_b === 1'b1) begin
        pulse_at.push_back(t);
        want = {beats[j-1], beats[j-2], beats[j-3], beats[j-4]};
        checks++;
        if (nn_b !== want) begin
          errors++;
          $display("FAIL b2b_nnin t=%0d got %h exp %h", t, nn_b, want);
        end
      end
    end
    pv[1] = 1'b0; ps[1] = 1'b0;
    checks++;
    if (pulse_at.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 3", pulse_at.size());
    end else begin
      checks++;
      if (pulse_at[1] - pulse_at[0] != 5 || pulse_at[2] - pulse_at[1] != 5) begin
        errors++;
        $display("FAIL b2b_spacing got %0d %0d exp 5 5", pulse_at[1] - pulse_at[0], pulse_at[2] - pulse_at[1]);
      end
    end
    checks++;
    if (fr_b !== 16'd3) begin
      errors++;
      $display("FAIL b2b_frames got %0d exp 3", fr_b);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] px [4];
    for (int i = 0; i < 4; i++) begin
      pv[0] = 1'b1; ps[0] = (i == 0); pd[0] = 8'($urandom);
      tick();
    end
    pv[0] = 1'b0; ps[0] = 1'b0;
    tick();
    checks++;
    if (rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL areset_in_wait rdy=%b exp 0", rdy_a);
    end
    #3 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (rdy_a !== 1'b1 || val_a !== 1'b0 || cnt_a !== 2'd0 || fr_a !== 16'd0 || nn_a !== 32'd0) begin
      errors++;
      $display("FAIL areset_wait rdy=%b val=%b cnt=%0d fr=%0d nn=%h exp 1 0 0 0 0", rdy_a, val_a, cnt_a, fr_a, nn_a);
    end
    #2 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pv[0] = 1'b1; ps[0] = (i == 0); pd[0] = 8'($urandom_range(1, 255));
      tick();
    end
    pd[0] = 8'h5A; ps[0] = 1'b0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (rdy_a !== 1'b1 || cnt_a !== 2'd0 || nn_a !== 32'd0) begin
      errors++;
      $display("FAIL areset_fill rdy=%b cnt=%0d nn=%h exp 1 0 0", rdy_a, cnt_a, nn_a);
    end
    pv[0] = 1'b0;
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      px[i] = 8'($urandom);
      pv[0] = 1'b1; ps[0] = (i == 0); pd[0] = px[i];
      tick();
    end
    pv[0] = 1'b0; ps[0] = 1'b0;
    checks++;
    if (val_a !== 1'b1 || nn_a !== {px[3], px[2], px[1], px[0]}) begin
      errors++;
      $display("FAIL areset_refill val=%b nn=%h exp 1 %h", val_a, nn_a, {px[3], px[2], px[1], px[0]});
    end
    tick();
    rv[0] = 1'b1;
    tick();
    rv[0] = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 2; i++) begin
        pv[i] = ($urandom % 4 != 0);
        ps[i] = ($urandom % 8 == 0);
        pd[i] = 8'($urandom);
        rv[i] = ($urandom % 3 == 0);
      end
      tick();
      checks++;
      if (val_a !== m_fire[0] || rdy_a !== !m_busy[0]) begin
        errors++;
        $display("FAIL rand_a_hs t=%0d val=%b rdy=%b exp %b %b", t, val_a, rdy_a, m_fire[0], !m_busy[0]);
      end
      checks++;
      if (cnt_a !== 2'(m_fill[0]) || fr_a !== 16'(m_frames[0])) begin
        errors++;
        $display("FAIL rand_a_cnt t=%0d cnt=%0d fr=%0d exp %0d %0d", t, cnt_a, fr_a, m_fill[0], m_frames[0]);
      end
      checks++;
      if (nn_a !== exp_small(0)) begin
        errors++;
        $display("FAIL rand_a_nnin t=%0d got %h exp %h", t, nn_a, exp_small(0));
      end
      checks++;
      if (val_b !== m_fire[1] || rdy_b !== !m_busy[1] || cnt_b !== 2'(m_fill[1]) || fr_b !== 16'(m_frames[1])) begin
        errors++;
        $display("FAIL rand_b_state t=%0d val=%b rdy=%b cnt=%0d fr=%0d exp %b %b %0d %0d",
                 t, val_b, rdy_b, cnt_b, fr_b, m_fire[1], !m_busy[1], m_fill[1], m_frames[1]);
      end
      checks++;
      if (nn_b !== exp_small(1)) begin
        errors++;
        $display("FAIL rand_b_nnin t=%0d got %h exp %h", t, nn_b, exp_small(1));
      end
    end
    idle();
  endtask

  task automatic test_big_frame();
    int early;
    int bad;
    early = 0;
    bad = -1;
    for (int k = 0; k < NBIG; k++) begin
      pv[2] = 1'b1; ps[2] = (k == 0); pd[2] = 8'(k); rv[2] = 1'b1;
      tick();
      if (k < NBIG - 1 && (val_c !== 1'b0 || rdy_c !== 1'b1)) early++;
    end
    pv[2] = 1'b0; ps[2] = 1'b0;
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL big_fill_cycles bad=%0d exp 0", early);
    end
    checks++;
    if (val_c !== 1'b1 || rdy_c !== 1'b0 || cnt_c !== 10'd0) begin
      errors++;
      $display("FAIL big_fire val=%b rdy=%b cnt=%0d exp 1 0 0", val_c, rdy_c, cnt_c);
    end
    for (int k = NBIG - 1; k >= 0; k--) begin
      if (nn_c[8*k +: 8] !== 8'(k)) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL big_nnin slot %0d got %h exp %h", bad, nn_c[8*bad +: 8], 8'(bad));
    end
    tick();
    rv[2] = 1'b0;
    checks++;
    if (val_c !== 1'b0 || rdy_c !== 1'b0 || fr_c !== 16'd1) begin
      errors++;
      $display("FAIL big_fire_ignores_result val=%b rdy=%b fr=%0d exp 0 0 1", val_c, rdy_c, fr_c);
    end
    tick();
    checks++;
    if (rdy_c !== 1'b0) begin
      errors++;
      $display("FAIL big_wait rdy=%b exp 0", rdy_c);
    end
    rv[2] = 1'b1;
    tick();
    rv[2] = 1'b0;
    checks++;
    if (rdy_c !== 1'b1) begin
      errors++;
      $display("FAIL big_release rdy=%b exp 1", rdy_c);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    #12 reset = 1'b0;
    #1;
    test_reset();
    test_frame();
    test_wait();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_big_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
